// File: rtl/parity_frame_tx.sv
// parity_frame_tx: even-parity frame source for the mux-based checker.
// Emits each accepted word as a registered parallel bundle and a serial stream.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    word handshake (in_ready decoded from state)
//   in_data, inject_err  word and parity-flip request, sampled at accept
//   frame_data/par/valid registered parallel frame, one-cycle update pulse
//   ser_out/valid/last   serial bits, data LSB-first then parity
//   busy, frame_cnt      state != IDLE, accepted-frame count (wraps)
module parity_frame_tx #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inject_err,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_par,
    output logic              frame_valid,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_DATA,
        SHIFT_PAR
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shnext;
    logic [IDX_W-1:0]  idx;
    logic              par;
    logic              accept;
    logic              in_par;

    // The parity slot doubles as the accept slot for back-to-back frames.
    assign in_ready = (state == IDLE) || (state == SHIFT_PAR);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign in_par   = (^in_data) ^ inject_err;
    // Shifting right keeps the next bit at position 0; ser_out is
    // registered, so it is loaded one bit ahead of the shift register.
    assign shnext   = shreg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            par         <= 1'b0;
            frame_data  <= '0;
            frame_par   <= 1'b0;
            frame_valid <= 1'b0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            ser_last    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= accept;
            if (accept) begin
                state      <= SHIFT_DATA;
                shreg      <= in_data;
                idx        <= '0;
                par        <= in_par;
                frame_data <= in_data;
                frame_par  <= in_par;
                frame_cnt  <= frame_cnt + 1'b1;
                ser_out    <= in_data[0];
                ser_valid  <= 1'b1;
                ser_last   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                    end
                    SHIFT_DATA: begin
                        if (idx == LAST) begin
                            state    <= SHIFT_PAR;
                            ser_out  <= par;
                            ser_last <= 1'b1;
                        end else begin
                            idx     <= idx + 1'b1;
                            shreg   <= shnext;
                            ser_out <= shnext[0];
                        end
                    end
                    SHIFT_PAR: begin
                        state     <= IDLE;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: directed bench for parity_frame_tx (DATA_W=3).
// Table of single frames plus back-to-back, backpressure, reset, wrap.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = '0;
    logic       inject_err = 1'b0;
    logic [2:0] frame_data;
    logic       frame_par;
    logic       frame_valid;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_cnt = '0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .inject_err(inject_err),
        .frame_data(frame_data), .frame_par(frame_par),
        .frame_valid(frame_valid),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [2:0] data;
        logic       inj;
        logic       par;
        logic [3:0] ser;
        logic       err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input vec_t v);
        in_valid   = 1'b1;
        in_data    = v.data;
        inject_err = v.inj;
        chk("ready_idle", 32'(in_ready), 1);
        step();
        in_valid   = 1'b0;
        in_data    = ~v.data;
        inject_err = ~v.inj;
        exp_cnt++;
        chk("fvalid", 32'(frame_valid), 1);
        chk("fdata", 32'(frame_data), 32'(v.data));
        chk("fpar", 32'(frame_par), 32'(v.par));
        chk("checker", 32'(^{frame_data, frame_par}), 32'(v.err));
        chk("fcnt", 32'(frame_cnt), 32'(exp_cnt));
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step();
                chk("fvalid_low", 32'(frame_valid), 0);
            end
            chk("ser_bit", 32'(ser_out), 32'(v.ser[i]));
            chk("ser_valid", 32'(ser_valid), 1);
            chk("ser_last", 32'(ser_last), (i == 3) ? 1 : 0);
        end
        step();
        chk("idle_sv", 32'(ser_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("hold_fdata", 32'(frame_data), 32'(v.data));
    endtask

    initial begin
        vec_t bb;
        logic [3:0] seq8a;
        logic [3:0] seq8b;

        vecs[0] = '{3'b101, 1'b0, 1'b0, 4'b0101, 1'b0};
        vecs[1] = '{3'b111, 1'b1, 1'b0, 4'b0111, 1'b1};
        vecs[2] = '{3'b000, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[3] = '{3'b110, 1'b1, 1'b1, 4'b1110, 1'b1};
        vecs[4] = '{3'b011, 1'b0, 1'b0, 4'b0011, 1'b0};
        vecs[5] = '{3'b100, 1'b0, 1'b1, 4'b1100, 1'b0};

        #12;
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk("rst_sv", 32'(ser_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_fdata", 32'({frame_data, frame_par}), 0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(in_ready), 1);

        foreach (vecs[k]) send_frame(vecs[k]);

        // back-to-back: 001 then 110, accepted in the parity slot
        seq8a = 4'b1001;
        seq8b = 4'b0110;
        in_valid = 1'b1;
        in_data = 3'b001;
        inject_err = 1'b0;
        step();
        in_data = 3'b110;
        exp_cnt++;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            chk("bb_sv", 32'(ser_valid), 1);
            chk("bb_bit", 32'(ser_out),
                32'((i < 4) ? seq8a[i] : seq8b[i-4]));
            chk("bb_last", 32'(ser_last), (i == 3 || i == 7) ? 1 : 0);
            if (i == 3) chk("bb_ready", 32'(in_ready), 1);
            if (i == 4) begin
                in_valid = 1'b0;
                exp_cnt++;
                chk("bb_fv2", 32'(frame_valid), 1);
                chk("bb_fd2", 32'(frame_data), 32'(3'b110));
                chk("bb_cnt", 32'(frame_cnt), 32'(exp_cnt));
            end
        end
        step();
        chk("bb_end_sv", 32'(ser_valid), 0);

        // backpressure: offer 111 while shifting 010
        bb = '{3'b010, 1'b0, 1'b1, 4'b1010, 1'b0};
        in_valid = 1'b1;
        in_data = bb.data;
        step();
        in_valid = 1'b0;
        exp_cnt++;
        step();
        in_valid = 1'b1;
        in_data = 3'b111;
        inject_err = 1'b1;
        chk("bp_ready", 32'(in_ready), 0);
        step();
        in_valid = 1'b0;
        inject_err = 1'b0;
        chk("bp_bit2", 32'(ser_out), 32'(bb.ser[2]));
        chk("bp_fdata", 32'(frame_data), 32'(bb.data));
        chk("bp_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("bp_fv", 32'(frame_valid), 0);
        step();
        chk("bp_par", 32'(ser_out), 32'(bb.par));
        chk("bp_last", 32'(ser_last), 1);
        step();

        // reset after the 2nd serial bit of 101
        in_valid = 1'b1;
        in_data = 3'b101;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_bit2", 32'(ser_out), 0);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        chk("ar_sv", 32'(ser_valid), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_out", 32'({ser_out, ser_last, frame_valid}), 0);
        chk("ar_frame", 32'({frame_data, frame_par}), 0);
        chk("ar_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst", 32'({in_ready, ser_valid, ser_last}), 32'(3'b100));
        end

        // sweep: 256 frames, back-to-back through the parity slot
        for (int n = 0; n < 256; n++) begin
            in_valid = 1'b1;
            in_data = 3'(n);
            inject_err = 1'b0;
            step();
            in_valid = 1'b0;
            chk("sw_even", 32'({frame_valid, ^{frame_data, frame_par}}),
                32'(2'b10));
            step();
            step();
            step();
        end
        chk("sw_wrap", 32'(frame_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
